alu_exec_pipe: RTL and testbench

Execution back end for the issue queue's output side. Per lane, it accepts one issued ALU instruction per cycle and reads its operands from the physical register file. It computes the result and, two cycles after issue, broadcasts writeback (`wb_valid`/`wb_phys_rd`) back to the issue queue's wakeup inputs, plus completion data for the ROB and register file. It is a fixed two-stage pipeline (RR, EX/WB) with no backpressure and flush support.

---
 rtl/alu_exec_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_alu_exec_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage (RR, EX/WB) ALU execution pipe with NUM_LANES independent lanes.
// Optional macro EXEC_BYPASS_EN forwards WB-stage results into RR register operand reads.
package common;
  localparam int unsigned DISPATCH_WIDTH       = 2;
  localparam int unsigned DISPATCH_ADDR_WIDTH  = 1;
  localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;
  localparam int unsigned ROB_ADDR_WIDTH       = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_cmd_t;

  typedef enum logic [1:0] {
    OP_REG = 2'd0,
    OP_IMM = 2'd1,
    OP_PC  = 2'd2
  } op_type_t;

  typedef struct packed {
    logic                            valid;
    alu_cmd_t                        alu_cmd;
    op_type_t                        op1_type;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] op1;
    op_type_t                        op2_type;
    logic [31:0]                     op2;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
    logic [31:0]                     pc;
    logic [31:0]                     instr;
    logic                            is_branch_instr;
  } rr_stage_t;

  typedef struct packed {
    logic                            valid;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [31:0]                     data;
    logic [DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
    logic [31:0]                     pc;
    logic [31:0]                     instr;
    logic                            is_branch_instr;
  } wb_stage_t;
endpackage

module alu_exec_pipe
  import common::*;
#(
  parameter int unsigned NUM_LANES = DISPATCH_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            issue_valid           [0:NUM_LANES-1],
  input  alu_cmd_t                        issue_alu_cmd         [0:NUM_LANES-1],
  input  op_type_t                        issue_op1_type        [0:NUM_LANES-1],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_op1             [0:NUM_LANES-1],
  input  op_type_t                        issue_op2_type        [0:NUM_LANES-1],
  input  logic [31:0]                     issue_op2             [0:NUM_LANES-1],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd         [0:NUM_LANES-1],
  input  logic [DISPATCH_ADDR_WIDTH-1:0]  issue_bank_addr       [0:NUM_LANES-1],
  input  logic [ROB_ADDR_WIDTH-1:0]       issue_rob_addr        [0:NUM_LANES-1],
  input  logic [31:0]                     issue_pc              [0:NUM_LANES-1],
  input  logic [31:0]                     issue_instr           [0:NUM_LANES-1],
  input  logic                            issue_is_branch_instr [0:NUM_LANES-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] rf_raddr1             [0:NUM_LANES-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] rf_raddr2             [0:NUM_LANES-1],
  input  logic [31:0]                     rf_rdata1             [0:NUM_LANES-1],
  input  logic [31:0]                     rf_rdata2             [0:NUM_LANES-1],
  output logic                            wb_valid              [0:NUM_LANES-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd            [0:NUM_LANES-1],
  output logic [31:0]                     wb_data               [0:NUM_LANES-1],
  output logic [DISPATCH_ADDR_WIDTH-1:0]  wb_bank_addr          [0:NUM_LANES-1],
  output logic [ROB_ADDR_WIDTH-1:0]       wb_rob_addr           [0:NUM_LANES-1],
  output logic [31:0]                     wb_pc                 [0:NUM_LANES-1],
  output logic [31:0]                     wb_instr              [0:NUM_LANES-1],
  output logic                            wb_is_branch_instr    [0:NUM_LANES-1]
);
  localparam int unsigned PRW = PHYS_REGS_ADDR_WIDTH;

  rr_stage_t rr_q [NUM_LANES];
  rr_stage_t rr_d [NUM_LANES];
  wb_stage_t wb_q [NUM_LANES];
  wb_stage_t wb_d [NUM_LANES];

  function automatic logic [31:0] alu_eval(alu_cmd_t cmd, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (cmd)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'd0, a < b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // RR capture: flush drops any same-cycle issue; payload holds when idle
  always_comb begin
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      rr_d[i]       = rr_q[i];
      rr_d[i].valid = 1'b0;
      if (issue_valid[i] && !flush) begin
        rr_d[i].valid           = 1'b1;
        rr_d[i].alu_cmd         = issue_alu_cmd[i];
        rr_d[i].op1_type        = issue_op1_type[i];
        rr_d[i].op1             = issue_op1[i];
        rr_d[i].op2_type        = issue_op2_type[i];
        rr_d[i].op2             = issue_op2[i];
        rr_d[i].phys_rd         = issue_phys_rd[i];
        rr_d[i].bank_addr       = issue_bank_addr[i];
        rr_d[i].rob_addr        = issue_rob_addr[i];
        rr_d[i].pc              = issue_pc[i];
        rr_d[i].instr           = issue_instr[i];
        rr_d[i].is_branch_instr = issue_is_branch_instr[i];
      end
    end
  end

  // Operand select, ALU and WB capture
  always_comb begin
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] result;
    reg1   = '0;
    reg2   = '0;
    opa    = '0;
    opb    = '0;
    result = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      reg1 = rf_rdata1[i];
      reg2 = rf_rdata2[i];
`ifdef EXEC_BYPASS_EN
      // Descending scan so the lowest matching lane is the last writer
      for (int j = int'(NUM_LANES) - 1; j >= 0; j--) begin
        if (wb_q[j].valid && (wb_q[j].phys_rd != '0)) begin
          if (wb_q[j].phys_rd == rr_q[i].op1)
            reg1 = wb_q[j].data;
          if (wb_q[j].phys_rd == rr_q[i].op2[PRW-1:0])
            reg2 = wb_q[j].data;
        end
      end
`endif
      case (rr_q[i].op1_type)
        OP_REG:  opa = reg1;
        OP_PC:   opa = rr_q[i].pc;
        default: opa = '0;
      endcase
      case (rr_q[i].op2_type)
        OP_REG:  opb = reg2;
        OP_IMM:  opb = rr_q[i].op2;
        default: opb = '0;
      endcase
      result = alu_eval(rr_q[i].alu_cmd, opa, opb);

      wb_d[i].valid           = rr_q[i].valid && !flush;
      wb_d[i].phys_rd         = rr_q[i].phys_rd;
      wb_d[i].data            = (rr_q[i].phys_rd == '0) ? '0 : result;
      wb_d[i].bank_addr       = rr_q[i].bank_addr;
      wb_d[i].rob_addr        = rr_q[i].rob_addr;
      wb_d[i].pc              = rr_q[i].pc;
      wb_d[i].instr           = rr_q[i].instr;
      wb_d[i].is_branch_instr = rr_q[i].is_branch_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        rr_q[i] <= '0;
        wb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        rr_q[i] <= rr_d[i];
        wb_q[i] <= wb_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
    assign rf_raddr1[g]          = rr_q[g].op1;
    assign rf_raddr2[g]          = rr_q[g].op2[PRW-1:0];
    assign wb_valid[g]           = wb_q[g].valid;
    assign wb_phys_rd[g]         = wb_q[g].phys_rd;
    assign wb_data[g]            = wb_q[g].data;
    assign wb_bank_addr[g]       = wb_q[g].bank_addr;
    assign wb_rob_addr[g]        = wb_q[g].rob_addr;
    assign wb_pc[g]              = wb_q[g].pc;
    assign wb_instr[g]           = wb_q[g].instr;
    assign wb_is_branch_instr[g] = wb_q[g].is_branch_instr;
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Bench for alu_exec_pipe: directed cases plus randomized traffic against a reference model.
// The model follows EXEC_BYPASS_EN the same way the design does.
module tb_alu_exec_pipe;
  import common::*;

  localparam int unsigned L   = DISPATCH_WIDTH;
  localparam int unsigned PRW = PHYS_REGS_ADDR_WIDTH;
  localparam int unsigned BW  = DISPATCH_ADDR_WIDTH;
  localparam int unsigned RW  = ROB_ADDR_WIDTH;

  typedef struct {
    logic            valid;
    logic [PRW-1:0]  rd;
    logic [31:0]     data;
    logic [BW-1:0]   bank;
    logic [RW-1:0]   rob;
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic            br;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  logic           issue_valid           [0:L-1];
  alu_cmd_t       issue_alu_cmd         [0:L-1];
  op_type_t       issue_op1_type        [0:L-1];
  logic [PRW-1:0] issue_op1             [0:L-1];
  op_type_t       issue_op2_type        [0:L-1];
  logic [31:0]    issue_op2             [0:L-1];
  logic [PRW-1:0] issue_phys_rd         [0:L-1];
  logic [BW-1:0]  issue_bank_addr       [0:L-1];
  logic [RW-1:0]  issue_rob_addr        [0:L-1];
  logic [31:0]    issue_pc              [0:L-1];
  logic [31:0]    issue_instr           [0:L-1];
  logic           issue_is_branch_instr [0:L-1];
  logic [PRW-1:0] rf_raddr1             [0:L-1];
  logic [PRW-1:0] rf_raddr2             [0:L-1];
  logic [31:0]    rf_rdata1             [0:L-1];
  logic [31:0]    rf_rdata2             [0:L-1];
  logic           wb_valid              [0:L-1];
  logic [PRW-1:0] wb_phys_rd            [0:L-1];
  logic [31:0]    wb_data               [0:L-1];
  logic [BW-1:0]  wb_bank_addr          [0:L-1];
  logic [RW-1:0]  wb_rob_addr           [0:L-1];
  logic [31:0]    wb_pc                 [0:L-1];
  logic [31:0]    wb_instr              [0:L-1];
  logic           wb_is_branch_instr    [0:L-1];

  logic [31:0] rf_mem [2**PRW];
  exp_t        prev   [L];
  int          checks;
  int          failures;

  alu_exec_pipe #(.NUM_LANES(L)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_alu_cmd(issue_alu_cmd),
    .issue_op1_type(issue_op1_type), .issue_op1(issue_op1),
    .issue_op2_type(issue_op2_type), .issue_op2(issue_op2),
    .issue_phys_rd(issue_phys_rd), .issue_bank_addr(issue_bank_addr),
    .issue_rob_addr(issue_rob_addr), .issue_pc(issue_pc), .issue_instr(issue_instr),
    .issue_is_branch_instr(issue_is_branch_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_phys_rd(wb_phys_rd), .wb_data(wb_data),
    .wb_bank_addr(wb_bank_addr), .wb_rob_addr(wb_rob_addr),
    .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_is_branch_instr(wb_is_branch_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only register file model with combinational reads
  for (genvar g = 0; g < L; g++) begin : g_rf
    assign rf_rdata1[g] = rf_mem[rf_raddr1[g]];
    assign rf_rdata2[g] = rf_mem[rf_raddr2[g]];
  end

  task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s lane=%0d observed=%h expected=%h", tag, lane, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_alu(alu_cmd_t cmd, logic [31:0] a, logic [31:0] b);
    logic [63:0] ext;
    ext = {{32{a[31]}}, a};
    case (cmd)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a + ~b + 32'd1;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'(ext >> b[4:0]);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  // Register value seen in RR: the previous cycle's surviving results forward when enabled
  function automatic logic [31:0] reg_value(logic [PRW-1:0] a);
`ifdef EXEC_BYPASS_EN
    for (int j = 0; j < L; j++)
      if (prev[j].valid && prev[j].rd == a && a != '0) return prev[j].data;
`endif
    return rf_mem[a];
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.valid = 1'b0; e.rd = '0; e.data = '0; e.bank = '0;
    e.rob = '0; e.pc = '0; e.instr = '0; e.br = 1'b0;
    return e;
  endfunction

  function automatic exp_t predict(int l);
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;
    case (issue_op1_type[l])
      OP_REG:  a = reg_value(issue_op1[l]);
      OP_PC:   a = issue_pc[l];
      default: a = 32'd0;
    endcase
    b = (issue_op2_type[l] == OP_REG) ? reg_value(issue_op2[l][PRW-1:0]) : issue_op2[l];
    e.valid = issue_valid[l];
    e.rd    = issue_phys_rd[l];
    e.data  = (issue_phys_rd[l] == '0) ? 32'd0 : ref_alu(issue_alu_cmd[l], a, b);
    e.bank  = issue_bank_addr[l];
    e.rob   = issue_rob_addr[l];
    e.pc    = issue_pc[l];
    e.instr = issue_instr[l];
    e.br    = issue_is_branch_instr[l];
    return e;
  endfunction

  // One clock: predict what the current inputs produce, then check the WB outputs
  task automatic tick();
    exp_t nxt [L];
    logic rst_now;
    rst_now = rst;
    for (int l = 0; l < L; l++) begin
      nxt[l] = predict(l);
      if (rst || flush) nxt[l].valid = 1'b0;
      if (rst) nxt[l] = zero_exp();
    end
    for (int l = 0; l < L; l++) begin
      if (rst) prev[l] = zero_exp();
      else if (flush) prev[l].valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < L; l++) begin
      chk("wb_valid", l, 32'(wb_valid[l]), 32'(prev[l].valid));
      if (prev[l].valid || rst_now) begin
        chk("wb_phys_rd", l, 32'(wb_phys_rd[l]), 32'(prev[l].rd));
        chk("wb_data", l, wb_data[l], prev[l].data);
        chk("wb_bank", l, 32'(wb_bank_addr[l]), 32'(prev[l].bank));
        chk("wb_rob", l, 32'(wb_rob_addr[l]), 32'(prev[l].rob));
        chk("wb_pc", l, wb_pc[l], prev[l].pc);
        chk("wb_instr", l, wb_instr[l], prev[l].instr);
        chk("wb_br", l, 32'(wb_is_branch_instr[l]), 32'(prev[l].br));
      end
      if (rst_now) begin
        chk("rst_raddr1", l, 32'(rf_raddr1[l]), 32'd0);
        chk("rst_raddr2", l, 32'(rf_raddr2[l]), 32'd0);
      end
    end
    prev = nxt;
  endtask

  task automatic set_lane(input int l, input alu_cmd_t cmd, input op_type_t t1, input logic [PRW-1:0] op1,
                          input op_type_t t2, input logic [31:0] op2, input logic [PRW-1:0] rd);
    issue_valid[l]           = 1'b1;
    issue_alu_cmd[l]         = cmd;
    issue_op1_type[l]        = t1;
    issue_op1[l]             = op1;
    issue_op2_type[l]        = t2;
    issue_op2[l]             = op2;
    issue_phys_rd[l]         = rd;
    issue_bank_addr[l]       = BW'($urandom);
    issue_rob_addr[l]        = RW'($urandom);
    issue_pc[l]              = $urandom;
    issue_instr[l]           = $urandom;
    issue_is_branch_instr[l] = 1'($urandom);
  endtask

  task automatic set_rand_lane(input int l);
    int c;
    logic [31:0] op2;
    op_type_t t2;
    c  = $urandom_range(0, 10);
    t2 = ($urandom_range(0, 1) == 0) ? OP_REG : OP_IMM;
    op2 = $urandom;
    if (t2 == OP_REG) op2[PRW-1:0] = PRW'($urandom_range(0, 15));
    set_lane(l, (c == 10) ? alu_cmd_t'(4'hF) : alu_cmd_t'(4'(c)),
             op_type_t'(2'($urandom_range(0, 2))), PRW'($urandom_range(0, 15)),
             t2, op2, PRW'($urandom_range(0, 15)));
    issue_valid[l] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle();
    for (int l = 0; l < L; l++) issue_valid[l] = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] rob_sent;
    logic [31:0]   byp_exp;
    int            cnt [L];
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 2**PRW; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'd0;
    rf_mem[3] = 32'h8000_0000;
    rf_mem[4] = 32'd1;
    rf_mem[5] = 32'd10;
    rf_mem[9] = 32'd0;
    for (int l = 0; l < L; l++) begin
      prev[l] = zero_exp();
      set_lane(l, ALU_ADD, OP_IMM, '0, OP_IMM, 32'd1, PRW'(1));
    end
    flush = 1'b0;

    // Reset held two cycles with issue_valid asserted
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Immediate add, first issue after reset
    idle();
    set_lane(0, ALU_ADD, OP_REG, PRW'(5), OP_IMM, 32'hFFFF_FFFF, PRW'(7));
    rob_sent = issue_rob_addr[0];
    tick();
    chk("first_issue_early", 0, 32'(wb_valid[0]), 32'd0);
    idle();
    tick();
    chk("imm_add_valid", 0, 32'(wb_valid[0]), 32'd1);
    chk("imm_add_rd", 0, 32'(wb_phys_rd[0]), 32'd7);
    chk("imm_add_data", 0, wb_data[0], 32'd9);
    chk("imm_add_rob", 0, 32'(wb_rob_addr[0]), 32'(rob_sent));

    // Shift and compare
    set_lane(0, ALU_SRA, OP_REG, PRW'(3), OP_IMM, 32'h21, PRW'(11));
    set_lane(1, ALU_SLTU, OP_REG, PRW'(4), OP_IMM, 32'hFFFF_FFFF, PRW'(12));
    tick();
    idle();
    set_lane(0, ALU_SLT, OP_REG, PRW'(4), OP_IMM, 32'hFFFF_FFFF, PRW'(13));
    tick();
    chk("sra_data", 0, wb_data[0], 32'hC000_0000);
    chk("sltu_data", 1, wb_data[1], 32'd1);
    idle();
    tick();
    chk("slt_data", 0, wb_data[0], 32'd0);

    // Lane1 produces p9 while lane0 reads p9 with a stale register file
    set_lane(1, ALU_ADD, OP_IMM, '0, OP_IMM, 32'h55, PRW'(9));
    tick();
    idle();
    set_lane(0, ALU_ADD, OP_REG, PRW'(9), OP_IMM, 32'd0, PRW'(14));
    tick();
    chk("byp_producer", 1, wb_data[1], 32'h55);
    idle();
    tick();
`ifdef EXEC_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'd0;
`endif
    chk("byp_consumer", 0, wb_data[0], byp_exp);

    // Flush kills in-flight work and a concurrent issue
    for (int l = 0; l < L; l++) set_lane(l, ALU_OR, OP_IMM, '0, OP_IMM, 32'h3, PRW'(20 + l));
    tick();
    flush = 1'b1;
    for (int l = 0; l < L; l++) set_lane(l, ALU_XOR, OP_IMM, '0, OP_IMM, 32'h5, PRW'(22 + l));
    tick();
    chk("flush_wb0", 0, 32'(wb_valid[0]), 32'd0);
    chk("flush_wb1", 1, 32'(wb_valid[1]), 32'd0);
    flush = 1'b0;
    idle();
    tick();
    chk("flush_drop0", 0, 32'(wb_valid[0]), 32'd0);
    chk("flush_drop1", 1, 32'(wb_valid[1]), 32'd0);

    // Eight back-to-back issues per lane
    for (int l = 0; l < L; l++) cnt[l] = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k < 8)
        for (int l = 0; l < L; l++)
          set_lane(l, ALU_ADD, OP_PC, '0, OP_IMM, 32'(k), PRW'(1 + k));
      tick();
      for (int l = 0; l < L; l++) if (wb_valid[l]) cnt[l]++;
    end
    for (int l = 0; l < L; l++) chk("b2b_count", l, 32'(cnt[l]), 32'd8);

    // Zero destination register
    idle();
    set_lane(0, ALU_ADD, OP_IMM, '0, OP_IMM, 32'd5, PRW'(0));
    tick();
    idle();
    tick();
    chk("p0_valid", 0, 32'(wb_valid[0]), 32'd1);
    chk("p0_data", 0, wb_data[0], 32'd0);

    // Randomized traffic with occasional flush and reset
    for (int k = 0; k < 400; k++) begin
      for (int l = 0; l < L; l++) set_rand_lane(l);
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
